// File: rtl/debug_board_loader.sv
// debug_board_loader: receives a framed, checksummed nibble stream on uio_in
// and presents a complete connect-four position for one-cycle loading.
module debug_board_loader #(
  parameter int unsigned ROWS = 8,
  parameter int unsigned COLS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     e_debug,
  input  logic [7:0]               uio_in,
  output logic [7:0]               uio_out,
  output logic [7:0]               uio_oe,
  output logic                     load_valid,
  output logic [ROWS*COLS*2-1:0]   board_load,
  output logic [2:0]               col_load,
  output logic                     player_load
);

  localparam int unsigned CELLS  = ROWS * COLS;
  localparam int unsigned BOARD_W = CELLS * 2;
  localparam int unsigned N_NIB  = CELLS / 2;
  localparam int unsigned K_W    = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam int unsigned COL_W  = 3;
  localparam int unsigned PIN_W  = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BOARD = 3'd1,
    S_META  = 3'd2,
    S_SUM   = 3'd3,
    S_LOAD  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [PIN_W-1:0]   sync1, sync2;
  logic               strb_d;
  logic [K_W-1:0]     k;
  logic [BOARD_W-1:0] stage;
  logic [COL_W-1:0]   stage_col;
  logic               stage_player;
  logic [3:0]         csum;
  logic               bad;
  logic               ack;
  logic               err;

  logic               rise_c, cap_c, sof_c, last_c, sum_ok_c;
  logic [3:0]         nib_c;
  logic               restart_c, store_c, meta_c, ack_c, fail_c, load_c;
  logic               unused_pins_c;

  // Pins 7:6 carry nothing for this block.
  assign unused_pins_c = ^uio_in[7:6];

  // A nibble carrying the reserved cell code 11 poisons the frame.
  function automatic logic nib_bad(input logic [3:0] n);
    return (n[1:0] == 2'b11) || (n[3:2] == 2'b11);
  endfunction

  // Two-flop synchronizer plus strobe history for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      strb_d <= 1'b0;
    end else begin
      sync1  <= uio_in[PIN_W-1:0];
      sync2  <= sync1;
      strb_d <= sync2[4];
    end
  end

  assign rise_c   = sync2[4] & ~strb_d;
  assign cap_c    = e_debug & rise_c;
  assign nib_c    = sync2[3:0];
  assign sof_c    = sync2[5];
  assign last_c   = (k == K_W'(N_NIB - 1));
  assign sum_ok_c = (nib_c == csum) && !bad && (32'(stage_col) < COLS);

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and datapath strobes; sof always restarts a frame.
  always_comb begin
    state_nx  = state;
    restart_c = 1'b0;
    store_c   = 1'b0;
    meta_c    = 1'b0;
    ack_c     = 1'b0;
    fail_c    = 1'b0;
    load_c    = 1'b0;
    if (!e_debug) begin
      state_nx = S_IDLE;
    end else begin
      if (state == S_LOAD) begin
        state_nx = S_IDLE;
      end
      if (cap_c && sof_c) begin
        restart_c = 1'b1;
        ack_c     = 1'b1;
        state_nx  = (N_NIB == 1) ? S_META : S_BOARD;
      end else if (cap_c) begin
        case (state)
          S_BOARD: begin
            store_c = 1'b1;
            ack_c   = 1'b1;
            if (last_c) begin
              state_nx = S_META;
            end
          end
          S_META: begin
            meta_c   = 1'b1;
            ack_c    = 1'b1;
            state_nx = S_SUM;
          end
          S_SUM: begin
            ack_c = 1'b1;
            if (sum_ok_c) begin
              load_c   = 1'b1;
              state_nx = S_LOAD;
            end else begin
              fail_c   = 1'b1;
              state_nx = S_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Staging, checksum, handshake flags and the loaded outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k            <= '0;
      stage        <= '0;
      stage_col    <= '0;
      stage_player <= 1'b0;
      csum         <= '0;
      bad          <= 1'b0;
      ack          <= 1'b0;
      err          <= 1'b0;
      load_valid   <= 1'b0;
      board_load   <= '0;
      col_load     <= '0;
      player_load  <= 1'b0;
      uio_oe       <= '0;
    end else begin
      uio_oe     <= e_debug ? 8'hC0 : 8'h00;
      load_valid <= load_c;
      if (ack_c) begin
        ack <= ~ack;
      end
      if (restart_c) begin
        stage[3:0] <= nib_c;
        k          <= K_W'(1);
        csum       <= nib_c;
        bad        <= nib_bad(nib_c);
        err        <= 1'b0;
      end else if (store_c) begin
        stage[{k, 2'b00} +: 4] <= nib_c;
        k                      <= k + K_W'(1);
        csum                   <= csum ^ nib_c;
        bad                    <= bad | nib_bad(nib_c);
      end
      if (meta_c) begin
        stage_col    <= nib_c[2:0];
        stage_player <= nib_c[3];
        csum         <= csum ^ nib_c;
      end
      if (fail_c) begin
        err <= 1'b1;
      end
      if (load_c) begin
        board_load  <= stage;
        col_load    <= stage_col;
        player_load <= stage_player;
      end
      if (!e_debug) begin
        k <= '0;
      end
    end
  end

  assign uio_out = {err, ack, 6'b00_0000};

endmodule
